// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and default constants for the interrupt sequencer.
//   irq_state_t  : sequencer FSM states (IDLE, REQ, SERVICE, RESTORE)
//   NUM_IRQ      : default number of request lines (index 0 = highest priority)
//   ADDR_W       : default vector address width
//   VECTOR_BASE  : default vector address of irq 0
//   VECTOR_STRIDE: default spacing between consecutive vectors
//   id_w()       : width of an irq index, never less than one bit
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int ADDR_W  = 20;

    localparam logic [ADDR_W-1:0] VECTOR_BASE   = 20'd16;
    localparam logic [ADDR_W-1:0] VECTOR_STRIDE = 20'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RESTORE = 2'd3
    } irq_state_t;

    // A single request line would give $clog2 = 0; keep the index at least
    // one bit wide so every port and register has a legal width.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : irq_pkg

// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
// Combinational fixed-priority encoder: reports the lowest set bit of the
// eligible vector, index 0 being the highest priority.
// Ports:
//   i_eligible [NUM_IRQ] : requests that may be selected this cycle
//   o_valid              : at least one eligible bit is set
//   o_index    [ID_W]    : index of the lowest set bit (0 when o_valid = 0)
// -----------------------------------------------------------------------------
module irq_priority_encoder #(
    parameter int NUM_IRQ = irq_pkg::NUM_IRQ,
    parameter int ID_W    = irq_pkg::id_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_eligible,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_index
);

    // Scan from the lowest priority upwards so the last hit (the lowest
    // index) is the one that sticks.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_valid = 1'b1;
                o_index = ID_W'(i);
            end
        end
    end

endmodule : irq_priority_encoder

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
// Prioritised, non-nesting interrupt controller sitting between peripheral
// request lines and the PC/control unit. Rising edges on i_irq_in latch into
// a pending register; the lowest-index pending, unmasked request (when
// globally enabled) is offered to the PC as a vector with a take/ack
// handshake. A one-cycle restore pulse follows the handler's return strobe.
//
// Build option:
//   IRQ_SYNC_EN - when defined, every i_irq_in bit passes through a two-flop
//                 synchronizer before edge detection (2 extra cycles of
//                 edge-to-pending latency). When undefined, i_irq_in must be
//                 synchronous to i_clock and feeds edge detection directly.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_irq_in      level request lines; rising edge raises a request
//   i_mask_wr     mask register write strobe
//   i_mask_data   new mask value (1 = blocked)
//   i_global_en   global interrupt enable
//   i_pc_ack      PC saved its return address and loaded o_irq_vector
//   i_irq_return  handler return (RETI) strobe
//   o_irq_take    request to the PC to jump to o_irq_vector
//   o_irq_vector  handler address
//   o_irq_id      index of the taken / in-service irq
//   o_in_service  high while a handler runs
//   o_restore_pc  one-cycle pulse: PC reloads its saved address
//   o_pending     pending register
//   o_mask        mask register
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int NUM_IRQ = irq_pkg::NUM_IRQ,
    parameter int ADDR_W  = irq_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(irq_pkg::VECTOR_BASE),
    parameter logic [ADDR_W-1:0] VECTOR_STRIDE = ADDR_W'(irq_pkg::VECTOR_STRIDE),
    parameter int ID_W    = irq_pkg::id_w(NUM_IRQ)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NUM_IRQ-1:0] i_irq_in,
    input  logic               i_mask_wr,
    input  logic [NUM_IRQ-1:0] i_mask_data,
    input  logic               i_global_en,
    input  logic               i_pc_ack,
    input  logic               i_irq_return,
    output logic               o_irq_take,
    output logic [ADDR_W-1:0]  o_irq_vector,
    output logic [ID_W-1:0]    o_irq_id,
    output logic               o_in_service,
    output logic               o_restore_pc,
    output logic [NUM_IRQ-1:0] o_pending,
    output logic [NUM_IRQ-1:0] o_mask
);

    import irq_pkg::*;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    irq_state_t         r_state;
    irq_state_t         w_state_next;

    logic [NUM_IRQ-1:0] w_irq_src;      // request lines as seen by edge detect
    logic [NUM_IRQ-1:0] r_irq_hist;     // previous-cycle copy of w_irq_src
    logic [NUM_IRQ-1:0] w_irq_rise;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_pending_clr;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_eligible;

    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_idx;
    logic [ADDR_W-1:0]  w_win_vector;

    logic               w_load_req;     // IDLE -> REQ this cycle
    logic               w_ack_taken;    // REQ -> SERVICE this cycle

    logic [ADDR_W-1:0]  r_irq_vector;
    logic [ID_W-1:0]    r_irq_id;

    // -------------------------------------------------------------------------
    // Optional input synchronizer
    // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync_meta;
    logic [NUM_IRQ-1:0] r_sync_out;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync_meta <= '0;
            r_sync_out  <= '0;
        end else begin
            r_sync_meta <= i_irq_in;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_irq_src = r_sync_out;
`else
    assign w_irq_src = i_irq_in;
`endif

    // -------------------------------------------------------------------------
    // Rising-edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_irq_hist <= '0;
        end else begin
            r_irq_hist <= w_irq_src;
        end
    end

    assign w_irq_rise = w_irq_src & ~r_irq_hist;

    // -------------------------------------------------------------------------
    // Pending register
    // The bit being acknowledged is cleared, but a fresh edge on that same
    // line in the same cycle wins so the new request is not lost.
    // Masked lines still latch; the mask only affects selection.
    // -------------------------------------------------------------------------
    assign w_ack_taken = (r_state == REQ) && i_pc_ack;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
            assign w_pending_clr[gi] = w_ack_taken && (r_irq_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pending_clr) | w_irq_rise;
        end
    end

    // -------------------------------------------------------------------------
    // Mask register: writable in any state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mask <= '0;
        end else if (i_mask_wr) begin
            r_mask <= i_mask_data;
        end
    end

    // -------------------------------------------------------------------------
    // Selection
    // -------------------------------------------------------------------------
    assign w_eligible = i_global_en ? (r_pending & ~r_mask) : '0;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .i_eligible (w_eligible),
        .o_valid    (w_win_valid),
        .o_index    (w_win_idx)
    );

    // Vector arithmetic is done at ADDR_W so any overflow wraps naturally.
    assign w_win_vector = VECTOR_BASE + (ADDR_W'(w_win_idx) * VECTOR_STRIDE);

    // -------------------------------------------------------------------------
    // Sequencer FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM: next state
    // Once in REQ the offer is committed: nothing but pc_ack (or reset) moves
    // it, regardless of mask, enable or newer higher-priority edges.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_req   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_next = REQ;
                    w_load_req   = 1'b1;
                end
            end
            REQ: begin
                if (i_pc_ack) begin
                    w_state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (i_irq_return) begin
                    w_state_next = RESTORE;
                end
            end
            RESTORE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Vector / id capture: loaded only when a request is offered, held
    // through service and afterwards until the next offer.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_irq_vector <= '0;
            r_irq_id     <= '0;
        end else if (w_load_req) begin
            r_irq_vector <= w_win_vector;
            r_irq_id     <= w_win_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: handshake flags decode directly from the registered state,
    // so they are glitch-free and drop to 0 the instant reset asserts.
    // -------------------------------------------------------------------------
    assign o_irq_take   = (r_state == REQ);
    assign o_in_service = (r_state == SERVICE);
    assign o_restore_pc = (r_state == RESTORE);
    assign o_irq_vector = r_irq_vector;
    assign o_irq_id     = r_irq_id;
    assign o_pending    = r_pending;
    assign o_mask       = r_mask;

endmodule : irq_sequencer

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Prioritised interrupt controller that sequences the program counter's interrupt entry and return.
- Latches rising edges on NUM_IRQ request lines and applies a mask and a global enable.
- Selects the highest-priority pending request and hands the PC a vector address with a take/ack handshake.
- Issues a one-cycle restore pulse when the handler returns.
- Sits between peripheral IRQ sources and the PC/control unit; only one interrupt is in service at a time (no nesting).

Parameters:
NUM_IRQ, 4, number of request lines; index 0 has the highest priority.
ADDR_W, 20, width of the vector address.
VECTOR_BASE, 20'd16, vector address for irq 0.
VECTOR_STRIDE, 20'd4, address spacing between consecutive vectors.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
irq_in  input  NUM_IRQ  level request lines; a rising edge raises a request.
mask_wr  input  1  write strobe for the mask register.
mask_data  input  NUM_IRQ  new mask value; bit=1 blocks that irq.
global_en  input  1  global interrupt enable.
pc_ack  input  1  PC has saved its return address and loaded irq_vector.
irq_return  input  1  handler return (RETI) strobe.
irq_take  output  1  request to the PC to jump to irq_vector.
irq_vector  output  ADDR_W  handler address.
irq_id  output  $clog2(NUM_IRQ)  index of the taken/in-service irq.
in_service  output  1  high while a handler runs.
restore_pc  output  1  one-cycle pulse telling the PC to reload its saved address.
pending  output  NUM_IRQ  current pending register.
mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset (async, reset=1): state=IDLE; pending=0; mask=0; edge-detect history=0; irq_take=0; irq_vector=0; irq_id=0; in_service=0; restore_pc=0. Reset asserted mid-handshake or mid-service abandons the operation; no restore_pc is issued.
- Edge detect: irq_in high at posedge k and low at posedge k-1 sets pending[i] at posedge k.
- Pending priority: set wins over the clear of the same bit in the same cycle.
- Masked bits still latch into pending; they are only excluded from selection.
- mask_wr loads mask_data at the posedge, in any state.
- eligible = pending & ~mask, gated by global_en. Winner = lowest set index.
- FSM states: IDLE, REQ, SERVICE, RESTORE.
- IDLE: if eligible≠0 -> REQ at the next posedge. On that edge:
  - irq_take becomes 1.
  - irq_id = winner.
  - irq_vector = VECTOR_BASE + winner*VECTOR_STRIDE, truncated to ADDR_W.
- Latency: pending visible at posedge k -> irq_take high after posedge k+1.
- REQ: irq_take, irq_vector and irq_id are held stable.
  - The request is never retracted, even if global_en drops, the mask changes, or a higher-priority irq arrives.
  - pc_ack sampled high -> SERVICE; irq_take=0; pending[irq_id] cleared; in_service=1.
- SERVICE: new edges keep latching into pending. irq_return sampled high -> RESTORE; in_service=0; restore_pc=1.
- RESTORE: lasts exactly one cycle; restore_pc=0 on exit -> IDLE. A further request can reach REQ no earlier than the cycle after IDLE is entered.
- Ignored inputs: pc_ack outside REQ; irq_return outside SERVICE.
- irq_vector and irq_id hold their last value outside REQ and SERVICE.

Optional Feature:
IRQ_SYNC_EN
- Defined: each irq_in bit passes through a two-flop synchronizer (reset 0) before edge detection, adding 2 cycles to edge-to-pending latency.
- Undefined: irq_in feeds edge detection directly and sources must be synchronous to clock.

Decomposition:
- Shared package irq_pkg:
  - state enum irq_state_t {IDLE, REQ, SERVICE, RESTORE}.
  - Constants ADDR_W=20, NUM_IRQ=4, VECTOR_BASE, VECTOR_STRIDE.
- Sub-module irq_priority_encoder: combinational; inputs eligible[NUM_IRQ]; outputs valid and index (lowest set bit). Instantiated once.

Test Plan:
- Single request: edge on irq_in[2], mask=0, global_en=1 -> pending[2] at k; irq_take=1, irq_id=2, irq_vector=24 at k+1. Then pc_ack -> in_service=1, pending=0.
- Priority: edges on irq 3 and irq 1 in the same cycle -> irq_id=1, vector=20, pending[3] stays 1. After irq_return and RESTORE -> irq_take with irq_id=3, vector=28.
- Mask/global gating: mask=4'b0010 with an edge on irq1 -> pending[1]=1, no irq_take. mask=0 but global_en=0 -> no irq_take. Setting global_en=1 -> irq_take within 1 cycle.
- Return sequence: irq_return during SERVICE -> restore_pc high exactly 1 cycle, then IDLE. irq_return in IDLE -> no restore_pc. pc_ack in IDLE -> no effect.
- Async reset while irq_take=1 in REQ -> all outputs 0 immediately, pending=0, no restore_pc. First edge after deassertion is serviced normally.
- IRQ_SYNC_EN defined: edge on irq_in[0] -> pending[0] set 2 cycles later than the non-synced build; vector=16.
